mdu_seq: RTL and testbench

Sequencer for the M-extension unit, sitting in the execute stage directly upstream of mult32. It accepts one M-type operation per valid/ready handshake and drives mult32's operands and function code. It waits the fixed multiplier latency and captures the product. DIV/DIVU/REM/REMU run on an internal radix-2 iterative divider; the result is returned with its destination tag over a valid/ready response port.

---
 rtl/mdu_seq.sv | 162 ++++++++++++++++
 tb/tb_mdu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: M-extension sequencer feeding mult32 and running a radix-2 restoring divider.
// Define MDU_DIV_EARLY_OUT_EN to skip the leading-zero bits of the dividend.
package mdu_pkg;
  typedef logic [3:0] AluFunc;
  localparam AluFunc MUL    = 4'd0;
  localparam AluFunc MULH   = 4'd1;
  localparam AluFunc MULHSU = 4'd2;
  localparam AluFunc MULHU  = 4'd3;
  localparam AluFunc DIV    = 4'd4;
  localparam AluFunc DIVU   = 4'd5;
  localparam AluFunc REM    = 4'd6;
  localparam AluFunc REMU   = 4'd7;
endpackage

module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MULT_LATENCY = 1,
  parameter int TAG_W        = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [31:0]      a_in,
  input  logic [31:0]      b_in,
  input  AluFunc           alufunc_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic [31:0]      mult_a_out,
  output logic [31:0]      mult_b_out,
  output AluFunc           mult_func_out,
  input  logic [31:0]      mult_result_in,
  output logic             resp_valid_out,
  input  logic             resp_ready_in,
  output logic [31:0]      resp_data_out,
  output logic [TAG_W-1:0] resp_tag_out,
  output logic             busy_out
);
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d, data_q, data_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  AluFunc func_q, func_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [5:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, sel_rem_q, sel_rem_d;
  logic is_mul, is_div, sgn, dz, ovf, fast;
  logic [31:0] a_mag, b_mag;
  logic [5:0] lz;
  logic [32:0] r_sh, diff;
  always_comb begin
    is_mul = alufunc_in[3:2] == 2'b00;
    is_div = alufunc_in[3:2] == 2'b01;
    sgn    = is_div && !alufunc_in[0];
    dz     = b_in == '0;
    ovf    = sgn && a_in == 32'h8000_0000 && b_in == '1;
    a_mag  = (sgn && a_in[31]) ? -a_in : a_in;
    b_mag  = (sgn && b_in[31]) ? -b_in : b_in;
`ifdef MDU_DIV_EARLY_OUT_EN
    lz = 6'd32;
    for (int i = 0; i < 32; i++) if (a_mag[i]) lz = 6'(31 - i);
`else
    lz = 6'd0;
`endif
    // Cases whose result is known at accept skip the iterations and pass through DIV_FIX
    fast = !is_div || dz || ovf || lz == 6'd32;
    r_sh = {rem_q, quo_q[31]};
    diff = r_sh - {1'b0, dvs_q};
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_valid_in) state_d = is_mul ? MUL_WAIT : fast ? DIV_FIX : DIV_RUN;
      MUL_WAIT: if (cnt_q == 6'(MULT_LATENCY)) state_d = DONE;
      DIV_RUN:  if (cnt_q == 6'd1) state_d = DIV_FIX;
      DIV_FIX:  state_d = DONE;
      DONE:     if (resp_ready_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    func_d    = func_q;
    data_d    = data_q;
    tag_d     = tag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sel_rem_d = sel_rem_q;
    if (state_q == IDLE && req_valid_in) begin
      tag_d     = tag_in;
      sel_rem_d = is_div && alufunc_in[1];
      qneg_d    = sgn && !fast && (a_in[31] ^ b_in[31]);
      rneg_d    = sgn && !fast && a_in[31];
      rem_d     = (is_div && dz) ? a_in : '0;
      quo_d     = !is_div ? '0 : dz ? '1 : ovf ? 32'h8000_0000 : a_mag << lz;
      dvs_d     = b_mag;
      cnt_d     = is_mul ? 6'd0 : 6'd32 - lz;
      if (is_mul) begin
        mult_a_d = a_in;
        mult_b_d = b_in;
        func_d   = alufunc_in;
      end
    end else if (state_q == MUL_WAIT) begin
      if (cnt_q == 6'(MULT_LATENCY)) data_d = mult_result_in;
      else cnt_d = cnt_q + 6'd1;
    end else if (state_q == DIV_RUN) begin
      rem_d = diff[32] ? r_sh[31:0] : diff[31:0];
      quo_d = {quo_q[30:0], !diff[32]};
      cnt_d = cnt_q - 6'd1;
    end else if (state_q == DIV_FIX) begin
      data_d = sel_rem_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      func_q    <= MUL;
      data_q    <= '0;
      tag_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
      func_q    <= func_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      sel_rem_q <= sel_rem_d;
    end
  end
  always_comb begin
    req_ready_out  = state_q == IDLE;
    busy_out       = state_q != IDLE;
    resp_valid_out = state_q == DONE;
    resp_data_out  = data_q;
    resp_tag_out   = tag_q;
    mult_a_out     = mult_a_q;
    mult_b_out     = mult_b_q;
    mult_func_out  = func_q;
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors for mdu_seq with a one-cycle mult32 model alongside.
module tb_mdu_seq;
  import mdu_pkg::*;
  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic        req_valid_in = 1'b0, req_ready_out;
  logic [31:0] a_in = '0, b_in = '0;
  AluFunc      alufunc_in = MUL;
  logic [4:0]  tag_in = '0;
  logic [31:0] mult_a_out, mult_b_out, mult_result_in = '0;
  AluFunc      mult_func_out;
  logic        resp_valid_out, resp_ready_in = 1'b0, busy_out;
  logic [31:0] resp_data_out;
  logic [4:0]  resp_tag_out;
  int vectors = 0, miscompares = 0;

  mdu_seq #(.MULT_LATENCY(1), .TAG_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .a_in(a_in), .b_in(b_in), .alufunc_in(alufunc_in), .tag_in(tag_in),
    .mult_a_out(mult_a_out), .mult_b_out(mult_b_out), .mult_func_out(mult_func_out),
    .mult_result_in(mult_result_in), .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_data_out(resp_data_out), .resp_tag_out(resp_tag_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b, input AluFunc f);
    logic [63:0] uu, ss, su;
    uu = {32'b0, a} * {32'b0, b};
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    return f == MUL ? uu[31:0] : f == MULH ? ss[63:32] : f == MULHSU ? su[63:32] : uu[63:32];
  endfunction

  always @(posedge clk_in) mult_result_in <= mul_model(mult_a_out, mult_b_out, mult_func_out);

  function automatic int div_lat(input logic [31:0] mag);
    int z;
    z = 32;
    for (int i = 0; i < 32; i++) if (mag[i]) z = 31 - i;
`ifdef MDU_DIV_EARLY_OUT_EN
    return 33 - z;
`else
    return 33 + 0 * z;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string nm, input AluFunc f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    alufunc_in = f;
    a_in = a;
    b_in = b;
    tag_in = tg;
    chk({nm, ".ready"}, 32'(req_ready_out), 32'd1);
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
    chk({nm, ".busy"}, 32'(busy_out), 32'd1);
    lat = 0;
    while (!resp_valid_out && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, ".data"}, resp_data_out, exp);
    chk({nm, ".tag"}, 32'(resp_tag_out), 32'(tg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in);
      #1;
      chk({nm, ".hold_valid"}, 32'(resp_valid_out), 32'd1);
      chk({nm, ".hold_data"}, resp_data_out, exp);
      chk({nm, ".hold_ready"}, 32'(req_ready_out), 32'd0);
    end
    @(negedge clk_in);
    resp_ready_in = 1'b1;
    req_valid_in = 1'b1;
    alufunc_in = MUL;
    @(posedge clk_in);
    #1;
    resp_ready_in = 1'b0;
    req_valid_in = 1'b0;
    chk({nm, ".valid_drop"}, 32'(resp_valid_out), 32'd0);
    chk({nm, ".no_accept_at_release"}, 32'(busy_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset.ready", 32'(req_ready_out), 32'd1);
    chk("reset.valid", 32'(resp_valid_out), 32'd0);
    chk("reset.busy", 32'(busy_out), 32'd0);
    chk("reset.data", resp_data_out, 32'd0);
    chk("reset.func", 32'(mult_func_out), 32'(MUL));
    @(negedge clk_in);
    rst_in = 1'b1;
    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 0);
    chk("mul.mult_a", mult_a_out, 32'd7);
    chk("mul.mult_b", mult_b_out, 32'hFFFF_FFFD);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 2, 4);
    run_op("mulh", MULH, 32'h8000_0000, 32'd2, 5'd17, 32'hFFFF_FFFF, 2, 0);
    run_op("div_neg", DIV, 32'hFFFF_FFEC, 32'd3, 5'd1, 32'hFFFF_FFFA, div_lat(32'd20), 0);
    run_op("rem_neg", REM, 32'hFFFF_FFEC, 32'd3, 5'd2, 32'hFFFF_FFFE, div_lat(32'd20), 0);
    run_op("div_negb", DIV, 32'd20, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFA, div_lat(32'd20), 0);
    run_op("rem_negb", REM, 32'd20, 32'hFFFF_FFFD, 5'd7, 32'd2, div_lat(32'd20), 0);
    run_op("divu_dz", DIVU, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_dz", REMU, 32'd100, 32'd0, 5'd9, 32'd100, 1, 0);
    run_op("rem_dz_neg", REM, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFB, 1, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, 0);
    run_op("divu_one", DIVU, 32'd1, 32'd1, 5'd13, 32'd1, div_lat(32'd1), 0);
    run_op("divu_zero", DIVU, 32'd0, 32'd5, 5'd14, 32'd0, div_lat(32'd0), 0);
    run_op("unknown", 4'hF, 32'd9, 32'd9, 5'd15, 32'd0, 1, 0);
    run_op("div_min", DIV, 32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, div_lat(32'h8000_0000), 0);
    @(negedge clk_in);
    req_valid_in = 1'b1;
    alufunc_in = DIVU;
    a_in = 32'hFFFF_FFFF;
    b_in = 32'd7;
    tag_in = 5'd21;
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk("rst_mid.ready", 32'(req_ready_out), 32'd1);
    chk("rst_mid.busy", 32'(busy_out), 32'd0);
    chk("rst_mid.valid", 32'(resp_valid_out), 32'd0);
    chk("rst_mid.data", resp_data_out, 32'd0);
    chk("rst_mid.tag", 32'(resp_tag_out), 32'd0);
    chk("rst_mid.mult_a", mult_a_out, 32'd0);
    chk("rst_mid.mult_b", mult_b_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk_in);
      #1;
      if (resp_valid_out) saw = 1'b1;
    end
    chk("rst_mid.no_resp", 32'(saw), 32'd0);
    run_op("divu_after_rst", DIVU, 32'hFFFF_FFFF, 32'd7, 5'd22, 32'h2492_4924, div_lat(32'hFFFF_FFFF), 0);
    run_op("remu_big", REMU, 32'hFFFF_FFFF, 32'd7, 5'd23, 32'd3, div_lat(32'hFFFF_FFFF), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
